// File: rtl/alu_md.sv
// Iterative multiply/divide unit with HI/LO registers (MIPS-style mult/div/mfhi/mflo/mthi/mtlo).
// Multiply is shift-add, divide is restoring, both one bit per cycle on operand magnitudes,
// with sign correction applied in a single FIX cycle before HI/LO are written.
`timescale 1ns/1ps
module alu_md #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned CWIDTH = $clog2(DWIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_i_valid,
   input  logic [4:0]        m_i_funct,
   input  logic [DWIDTH-1:0] m_i_data_rs,
   input  logic [DWIDTH-1:0] m_i_data_rt,
   input  logic              m_i_flush,
   output logic              m_o_busy,
   output logic              m_o_stall,
   output logic [DWIDTH-1:0] m_o_value,
   output logic              m_o_value_valid,
   output logic              m_o_done,
   output logic              m_o_div_zero
);

   localparam logic [4:0] FnMult  = 5'd20;
   localparam logic [4:0] FnMultu = 5'd21;
   localparam logic [4:0] FnDiv   = 5'd22;
   localparam logic [4:0] FnDivu  = 5'd23;
   localparam logic [4:0] FnMfhi  = 5'd24;
   localparam logic [4:0] FnMflo  = 5'd25;
   localparam logic [4:0] FnMthi  = 5'd26;
   localparam logic [4:0] FnMtlo  = 5'd27;
   localparam logic [CWIDTH-1:0] CntLast = CWIDTH'(DWIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e                state_q;
   logic [DWIDTH-1:0]     hi_q, lo_q, dvs_q, value_q;
   logic [2*DWIDTH-1:0]   acc_q;
   logic [CWIDTH-1:0]     cnt_q;
   logic                  neg_q, neg_rem_q, is_mul_q, div0_pend_q;
   logic                  busy_q, done_q, value_valid_q, div_zero_q;

   logic                  op_valid, accept, signed_op, rs_neg, rt_neg;
   logic [DWIDTH-1:0]     rs_mag, rt_mag, fix_hi, fix_lo;
   logic [DWIDTH:0]       mul_sum, div_diff;
   logic [2*DWIDTH-1:0]   mul_next, div_next, prod_fix;
   logic [CWIDTH-1:0]     cnt_inc;

   assign op_valid  = (m_i_funct >= FnMult) && (m_i_funct <= FnMtlo);
   assign accept    = m_i_valid & op_valid & ~busy_q & ~m_i_flush;
   assign m_o_stall = m_i_valid & op_valid & busy_q;

   assign m_o_busy        = busy_q;
   assign m_o_value       = value_q;
   assign m_o_value_valid = value_valid_q;
   assign m_o_done        = done_q;
   assign m_o_div_zero    = div_zero_q;

   // Operand magnitudes, iteration datapath and FIX-cycle sign correction
   always_comb begin
      signed_op = (m_i_funct == FnMult) || (m_i_funct == FnDiv);
      rs_neg    = signed_op & m_i_data_rs[DWIDTH-1];
      rt_neg    = signed_op & m_i_data_rt[DWIDTH-1];
      rs_mag    = rs_neg ? -m_i_data_rs : m_i_data_rs;
      rt_mag    = rt_neg ? -m_i_data_rt : m_i_data_rt;
      cnt_inc   = cnt_q + CWIDTH'(1);
      // Shift-add: upper half accumulates the multiplicand, carry enters at the top on shift
      mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + {1'b0, dvs_q};
      mul_next  = acc_q[0] ? {mul_sum, acc_q[DWIDTH-1:1]} : {1'b0, acc_q[2*DWIDTH-1:1]};
      // Restoring divide: partial remainder is the top DWIDTH+1 bits after a left shift
      div_diff  = acc_q[2*DWIDTH-1:DWIDTH-1] - {1'b0, dvs_q};
      div_next  = div_diff[DWIDTH] ? {acc_q[2*DWIDTH-2:0], 1'b0}
                                   : {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
      prod_fix  = neg_q ? -acc_q : acc_q;
      if (is_mul_q) begin
         fix_hi = prod_fix[2*DWIDTH-1:DWIDTH];
         fix_lo = prod_fix[DWIDTH-1:0];
      end else begin
         fix_hi = neg_rem_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
         fix_lo = neg_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
      end
   end

   // Control FSM with HI/LO, iteration state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         hi_q          <= '0;
         lo_q          <= '0;
         dvs_q         <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         neg_q         <= 1'b0;
         neg_rem_q     <= 1'b0;
         is_mul_q      <= 1'b0;
         div0_pend_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         div_zero_q    <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         value_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  div_zero_q <= 1'b0;
                  case (m_i_funct)
                     FnMult, FnMultu: begin
                        state_q  <= StMul;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= {{DWIDTH{1'b0}}, rt_mag};
                        dvs_q    <= rs_mag;
                        neg_q    <= rs_neg ^ rt_neg;
                        is_mul_q <= 1'b1;
                     end
                     FnDiv, FnDivu: begin
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        is_mul_q <= 1'b0;
                        if (m_i_data_rt == '0) begin
                           // Skip iteration; FIX writes the raw dividend and all-ones quotient
                           state_q     <= StFix;
                           acc_q       <= {m_i_data_rs, {DWIDTH{1'b1}}};
                           neg_q       <= 1'b0;
                           neg_rem_q   <= 1'b0;
                           div0_pend_q <= 1'b1;
                        end else begin
                           state_q     <= StDiv;
                           acc_q       <= {{DWIDTH{1'b0}}, rs_mag};
                           dvs_q       <= rt_mag;
                           neg_q       <= rs_neg ^ rt_neg;
                           neg_rem_q   <= rs_neg;
                           div0_pend_q <= 1'b0;
                        end
                     end
                     FnMfhi: begin
                        value_q       <= hi_q;
                        value_valid_q <= 1'b1;
                     end
                     FnMflo: begin
                        value_q       <= lo_q;
                        value_valid_q <= 1'b1;
                     end
                     FnMthi:  hi_q <= m_i_data_rs;
                     FnMtlo:  lo_q <= m_i_data_rs;
                     default: ;
                  endcase
               end
            end
            StMul, StDiv: begin
               if (m_i_flush) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= (state_q == StMul) ? mul_next : div_next;
                  cnt_q <= cnt_inc;
                  if (cnt_inc == CntLast) state_q <= StFix;
               end
            end
            StFix: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               if (!m_i_flush) begin
                  hi_q       <= fix_hi;
                  lo_q       <= fix_lo;
                  done_q     <= 1'b1;
                  div_zero_q <= div0_pend_q;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at DWIDTH=32.
`timescale 1ns/1ps
module tb_alu_md;

   localparam logic [4:0] FnMult  = 5'd20;
   localparam logic [4:0] FnMultu = 5'd21;
   localparam logic [4:0] FnDiv   = 5'd22;
   localparam logic [4:0] FnDivu  = 5'd23;
   localparam logic [4:0] FnMfhi  = 5'd24;
   localparam logic [4:0] FnMflo  = 5'd25;
   localparam logic [4:0] FnMthi  = 5'd26;
   localparam logic [4:0] FnMtlo  = 5'd27;

   logic        clk, rst, valid, flush;
   logic [4:0]  funct;
   logic [31:0] rs, rt;
   logic        busy, stall, value_valid, done, div_zero;
   logic [31:0] value;

   int checks = 0;
   int errors = 0;

   alu_md #(.DWIDTH(32)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .m_i_valid       (valid),
      .m_i_funct       (funct),
      .m_i_data_rs     (rs),
      .m_i_data_rt     (rt),
      .m_i_flush       (flush),
      .m_o_busy        (busy),
      .m_o_stall       (stall),
      .m_o_value       (value),
      .m_o_value_valid (value_valid),
      .m_o_done        (done),
      .m_o_div_zero    (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation for one cycle; returns just after the accepting edge
   task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1;
      funct = f;
      rs    = a;
      rt    = b;
      step();
      valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_busy);
      int n = 0;
      while (busy && n < 100) begin
         n++;
         step();
      end
      check({tag, " busy cycles"}, 64'(n), 64'(exp_busy));
      check({tag, " done"}, 64'(done), 64'd1);
   endtask

   task automatic read_chk(input string tag, input logic use_hi, input logic [31:0] exp);
      issue(use_hi ? FnMfhi : FnMflo, 32'h0, 32'h0);
      check({tag, " value_valid"}, 64'(value_valid), 64'd1);
      check({tag, " value"}, 64'(value), 64'(exp));
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      read_chk({tag, " HI"}, 1'b1, hi);
      read_chk({tag, " LO"}, 1'b0, lo);
   endtask

   initial begin
      int d;
      int n;
      rst = 1'b0; valid = 1'b0; flush = 1'b0; funct = 5'd0; rs = '0; rt = '0;
      #2;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst value", 64'(value), 64'd0);
      check("rst value_valid", 64'(value_valid), 64'd0);
      check("rst div_zero", 64'(div_zero), 64'd0);
      step();
      step();
      rst = 1'b1;

      // Signed multiply -3 * 5
      issue(FnMult, 32'hFFFF_FFFD, 32'h0000_0005);
      wait_done("mult", 33);
      step();
      check("mult done pulse", 64'(done), 64'd0);
      check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      issue(FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu", 33);
      check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

      // -7 / 2 and 7 / -2: remainder follows the dividend sign
      issue(FnDiv, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done("div neg", 33);
      check_hilo("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      issue(FnDiv, 32'h0000_0007, 32'hFFFF_FFFE);
      wait_done("div negdvs", 33);
      check_hilo("div negdvs", 32'h0000_0001, 32'hFFFF_FFFD);

      issue(FnDivu, 32'd100, 32'd7);
      wait_done("divu", 33);
      check_hilo("divu", 32'd2, 32'd14);

      // Signed overflow case
      issue(FnDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div ovf", 33);
      check("div ovf div_zero", 64'(div_zero), 64'd0);
      check_hilo("div ovf", 32'h0, 32'h8000_0000);

      // Divide by zero
      issue(FnDivu, 32'h0000_000A, 32'h0);
      wait_done("divz", 1);
      check("divz div_zero", 64'(div_zero), 64'd1);
      check_hilo("divz", 32'h0000_000A, 32'hFFFF_FFFF);

      issue(FnDivu, 32'h0000_000A, 32'h0);
      wait_done("divz2", 1);
      step();
      step();
      check("divz2 div_zero held", 64'(div_zero), 64'd1);
      issue(FnMtlo, 32'h0000_0055, 32'h0);
      check("mtlo clears div_zero", 64'(div_zero), 64'd0);
      check("mtlo no busy", 64'(busy), 64'd0);
      read_chk("mtlo LO", 1'b0, 32'h0000_0055);

      // mflo held against an in-flight mult
      issue(FnMult, 32'd7, 32'd6);
      valid = 1'b1;
      funct = FnMflo;
      n = 0;
      while (stall && n < 100) begin
         n++;
         step();
      end
      check("stall cycles", 64'(n), 64'd33);
      check("stall done", 64'(done), 64'd1);
      step();
      valid = 1'b0;
      check("stalled mflo valid", 64'(value_valid), 64'd1);
      check("stalled mflo value", 64'(value), 64'h2A);
      step();
      check("value_valid pulse", 64'(value_valid), 64'd0);
      check("value hold", 64'(value), 64'h2A);

      // Flush on the 10th MUL cycle
      issue(FnMthi, 32'h1234_5678, 32'h0);
      issue(FnMult, 32'd3, 32'd4);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush done", 64'(done), 64'd0);
      d = 0;
      repeat (40) begin
         step();
         if (done) d++;
      end
      check("flush no done", 64'(d), 64'd0);
      read_chk("flush HI", 1'b1, 32'h1234_5678);

      // Asynchronous reset mid-divide
      issue(FnDivu, 32'd100, 32'd7);
      repeat (5) step();
      rst = 1'b0;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst value", 64'(value), 64'd0);
      check("arst value_valid", 64'(value_valid), 64'd0);
      check("arst done", 64'(done), 64'd0);
      check("arst div_zero", 64'(div_zero), 64'd0);
      step();
      rst = 1'b1;
      read_chk("arst LO", 1'b0, 32'h0);
      read_chk("arst HI", 1'b1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
